// File: rtl/fft_sched_pkg.sv
// Shared types and default constants for the FFT frame scheduler.
// State encoding plus default frame length / stall tolerance.
package fft_sched_pkg;

  localparam int FRAME_LEN_DEF = 1024;
  localparam int STALL_MAX_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    STREAM,
    DONE
  } state_e;

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Channel FIFO and FFT sink signals of the frame scheduler.
// master: the scheduler; slave: FIFOs, triggers and FFT sink.
interface fft_frame_scheduler_if;
  import fft_sched_pkg::*;

  logic [1:0] ch_en;
  logic [1:0] ch_end;
  logic [1:0] ch_empty;
  logic [7:0] ch_data0;
  logic [7:0] ch_data1;
  logic [1:0] ch_rdreq;
  logic [1:0] ch_rearm;
  logic       snk_ready;
  logic       snk_valid;
  logic       snk_sop;
  logic       snk_eop;
  logic [7:0] snk_real;
  logic       frame_ch;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  modport master (
    input  ch_en, ch_end, ch_empty,
    input  ch_data0, ch_data1, snk_ready,
    output ch_rdreq, ch_rearm,
    output snk_valid, snk_sop, snk_eop, snk_real,
    output frame_ch, busy, frame_done, underrun
  );

  modport slave (
    output ch_en, ch_end, ch_empty,
    output ch_data0, ch_data1, snk_ready,
    input  ch_rdreq, ch_rearm,
    input  snk_valid, snk_sop, snk_eop, snk_real,
    input  frame_ch, busy, frame_done, underrun
  );

endinterface

// File: rtl/fft_sched_rr_arb.sv
// Two-requester round-robin arbiter with a preferred-channel pointer.
// Pointer starts at channel 0 and moves past each served channel.
module fft_sched_rr_arb
  import fft_sched_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_o,
  output logic       valid_o
);

  logic pref_q;
  logic pref_d;

  // grant the preferred requester if asking, otherwise the other one
  always_comb begin
    valid_o = |req_i;
    gnt_o   = req_i[pref_q] ? pref_q : ~pref_q;
  end

  // after a grant is taken, prefer the channel not just served
  always_comb begin
    pref_d = pref_q;
    if (take_i && valid_o) pref_d = ~gnt_o;
  end

  // preferred-channel register
  always_ff @(posedge Clk) begin
    if (Reset) pref_q <= 1'b0;
    else       pref_q <= pref_d;
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Streams complete frames from two capture FIFOs into an FFT sink.
// Optional zero-padding on FIFO underrun: FFT_SCHED_UNDERRUN_PAD_EN.
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int STALL_MAX = STALL_MAX_DEF
) (
  input logic                   Clk,
  input logic                   Reset,
  fft_frame_scheduler_if.master bus
);

  localparam int CW = $clog2(FRAME_LEN) + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LEN  = cnt_t'(FRAME_LEN);
  localparam cnt_t LAST = cnt_t'(FRAME_LEN - 1);

  if (FRAME_LEN < 16 || FRAME_LEN > 4096 ||
      (FRAME_LEN & (FRAME_LEN - 1)) != 0 ||
      STALL_MAX < 1) begin : g_bad_cfg
    $error("fft_frame_scheduler: bad FRAME_LEN or STALL_MAX");
  end

  state_e state_q, state_d;
  logic   ch_q, ch_d;
  cnt_t   issued_q, issued_d;
  cnt_t   beat_q, beat_d;
  logic   valid_q;
  logic   padb_q;
  logic   pad_q;
  logic   more;
  logic   rd_any;
  logic   pad_issue;
  logic   done_s;
  logic   take;
  logic   arb_gnt;
  logic   arb_valid;
  logic   empty_sel;
  logic   [1:0] req;
  logic   [7:0] sel_data;

  assign req       = bus.ch_en & bus.ch_end;
  assign empty_sel = bus.ch_empty[ch_q];
  assign sel_data  = ch_q ? bus.ch_data1 : bus.ch_data0;

  fft_sched_rr_arb u_arb (
    .Clk     (Clk),
    .Reset   (Reset),
    .req_i   (req),
    .take_i  (take),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  // frame FSM: next state, read/pad issue and beat counting
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    issued_d  = issued_q;
    beat_d    = beat_q;
    more      = 1'b0;
    rd_any    = 1'b0;
    pad_issue = 1'b0;
    done_s    = 1'b0;
    take      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) state_d = GRANT;
      end
      GRANT: begin
        take = 1'b1;
        if (arb_valid) begin
          ch_d     = arb_gnt;
          issued_d = '0;
          beat_d   = '0;
          state_d  = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        more      = issued_q < LEN;
        rd_any    = bus.snk_ready & ~empty_sel &
                    more & ~pad_q & ~Reset;
        pad_issue = bus.snk_ready & more &
                    pad_q & ~Reset;
        if (rd_any || pad_issue)
          issued_d = issued_q + cnt_t'(1);
        if (valid_q) begin
          beat_d = beat_q + cnt_t'(1);
          if (beat_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        done_s  = ~Reset;
        state_d = IDLE;
      end
    endcase
  end

  // state, channel, counters and sink beat pipeline
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      ch_q     <= 1'b0;
      issued_q <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
      padb_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      issued_q <= issued_d;
      beat_q   <= beat_d;
      valid_q  <= rd_any | pad_issue;
      padb_q   <= pad_issue;
    end
  end

`ifdef FFT_SCHED_UNDERRUN_PAD_EN
  localparam int SW = $clog2(STALL_MAX + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          pad_d;
  logic          unr_q, unr_d;

  // count consecutive starved cycles; switch to zero padding at limit
  always_comb begin
    stall_d = stall_q;
    pad_d   = pad_q;
    unr_d   = unr_q;
    if (state_q == GRANT) begin
      stall_d = '0;
      pad_d   = 1'b0;
    end else if (state_q == STREAM && !pad_q && more) begin
      if (bus.snk_ready && empty_sel) begin
        if (stall_q == SW'(STALL_MAX - 1)) begin
          pad_d = 1'b1;
          unr_d = 1'b1;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end else begin
        stall_d = '0;
      end
    end
  end

  // stall counter, pad mode and sticky underrun flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_q <= '0;
      pad_q   <= 1'b0;
      unr_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      pad_q   <= pad_d;
      unr_q   <= unr_d;
    end
  end

  assign bus.underrun = unr_q;
`else
  assign pad_q        = 1'b0;
  assign bus.underrun = 1'b0;
`endif

  // read strobes, rearm pulse and sink outputs
  always_comb begin
    bus.ch_rdreq   = {rd_any & ch_q, rd_any & ~ch_q};
    bus.ch_rearm   = {done_s & ch_q, done_s & ~ch_q};
    bus.snk_valid  = valid_q;
    bus.snk_real   = (valid_q && !padb_q) ? sel_data : 8'd0;
    bus.snk_sop    = valid_q && (beat_q == '0);
    bus.snk_eop    = valid_q && (beat_q == LAST);
    bus.frame_ch   = ch_q;
    bus.busy       = (state_q == GRANT) || (state_q == STREAM);
    bus.frame_done = done_s;
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench: FIFO model, queue scoreboard, round-robin model.
// Pad tests follow FFT_SCHED_UNDERRUN_PAD_EN when it is defined.
module tb_fft_frame_scheduler;
  import fft_sched_pkg::*;

  localparam int N = 1024;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic flush = 1'b0;

  fft_frame_scheduler_if bus();

  fft_frame_scheduler #(
    .FRAME_LEN (N),
    .STALL_MAX (64)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  logic [7:0] mem0 [0:4095];
  logic [7:0] mem1 [0:4095];
  int wr0 = 0;
  int wr1 = 0;
  int rd0 = 0;
  int rd1 = 0;

  assign bus.ch_empty = {wr1 == rd1, wr0 == rd0};

  // non-showahead FIFO: data appears the cycle after rdreq
  always @(posedge Clk) begin
    if (flush) begin
      rd0 <= wr0;
      rd1 <= wr1;
    end else begin
      if (bus.ch_rdreq[0]) begin
        bus.ch_data0 <= mem0[rd0[11:0]];
        rd0 <= rd0 + 1;
      end
      if (bus.ch_rdreq[1]) begin
        bus.ch_data1 <= mem1[rd1[11:0]];
        rd1 <= rd1 + 1;
      end
    end
  end

  logic [7:0] expq0 [$];
  logic [7:0] expq1 [$];
  int n_cmp = 0;
  int n_bad = 0;
  int last_ch = 1;
  int cyc = 0;
  int last_eop = -1;
  int sop_cyc = -1;
  int min_gap = 1000000;
  int beats, dat_err, se_err, rd_bad;
  int rearm_ok, rearm_bad, done_cnt;

  task automatic chk(input string tag, input longint obs,
                     input longint expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int rr(input logic [1:0] r);
    if (r == 2'b11) return (last_ch == 0) ? 1 : 0;
    return r[1] ? 1 : 0;
  endfunction

  task automatic push(input int c, input int n);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom);
      if (c == 0) begin
        mem0[wr0[11:0]] = v;
        wr0++;
        expq0.push_back(v);
      end else begin
        mem1[wr1[11:0]] = v;
        wr1++;
        expq1.push_back(v);
      end
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge Clk);
    flush = 1'b0;
    expq0.delete();
    expq1.delete();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    last_ch = 1;
    last_eop = -1;
  endtask

  task automatic watch(input int ec, input bit tog,
                       input int budget, input int stop_at);
    logic [7:0] ev;
    beats = 0; dat_err = 0; se_err = 0; rd_bad = 0;
    rearm_ok = 0; rearm_bad = 0; done_cnt = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge Clk);
      cyc++;
      if (bus.ch_rdreq != 2'b00 && !bus.snk_ready) rd_bad++;
      if (bus.ch_rdreq[1-ec]) rd_bad++;
      if (bus.snk_sop !== (bus.snk_valid && beats == 0)) se_err++;
      if (bus.snk_eop !== (bus.snk_valid && beats == N-1)) se_err++;
      if (bus.snk_valid) begin
        ev = 8'd0;
        if (ec == 0 && expq0.size() > 0) ev = expq0.pop_front();
        if (ec == 1 && expq1.size() > 0) ev = expq1.pop_front();
        if (bus.snk_real !== ev) dat_err++;
        if (bus.snk_sop) begin
          sop_cyc = cyc;
          if (last_eop >= 0 && cyc - last_eop < min_gap)
            min_gap = cyc - last_eop;
        end
        if (bus.snk_eop) last_eop = cyc;
        beats++;
      end else if (bus.snk_real !== 8'd0) begin
        dat_err++;
      end
      if (bus.ch_rearm[ec]) rearm_ok++;
      if (bus.ch_rearm[1-ec]) rearm_bad++;
      if (bus.frame_done) done_cnt++;
      if (bus.frame_done) break;
      if (stop_at > 0 && beats == stop_at + 1) break;
      bus.snk_ready = tog ? ~bus.snk_ready : 1'b1;
    end
  endtask

  initial begin
    int ec;
    int bad6;
    bus.ch_en = 2'b00;
    bus.ch_end = 2'b00;
    bus.snk_ready = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_valid", bus.snk_valid, 0);
    chk("rst_rdreq", bus.ch_rdreq, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_ch", bus.frame_ch, 0);
    chk("rst_underrun", bus.underrun, 0);
    chk("rst_rearm", bus.ch_rearm, 0);
    Reset = 1'b0;
    last_ch = 1;

    push(0, N);
    bus.ch_en = 2'b11;
    bus.ch_end = 2'b01;
    bus.snk_ready = 1'b1;
    ec = rr(bus.ch_en & bus.ch_end);
    watch(ec, 1'b0, 3000, 0);
    bus.ch_end = 2'b00;
    chk("t1_beats", beats, N);
    chk("t1_data", dat_err, 0);
    chk("t1_sop_eop", se_err, 0);
    chk("t1_span", last_eop - sop_cyc, N-1);
    chk("t1_frame_ch", bus.frame_ch, ec);
    chk("t1_rearm0", rearm_ok, 1);
    chk("t1_rearm1", rearm_bad, 0);
    chk("t1_rdreq", rd_bad, 0);
    last_ch = ec;
    @(negedge Clk);
    chk("t1_rearm_end", bus.ch_rearm, 0);
    chk("t1_done_end", bus.frame_done, 0);
    chk("t1_idle_busy", bus.busy, 0);

    do_reset();
    push(0, 2*N);
    push(1, 2*N);
    bus.ch_end = 2'b11;
    min_gap = 1000000;
    for (int f = 0; f < 4; f++) begin
      ec = rr(2'b11);
      chk("t2_order", ec, f % 2);
      watch(ec, 1'b0, 3000, 0);
      if (f == 3) bus.ch_end = 2'b00;
      chk("t2_frame_ch", bus.frame_ch, ec);
      chk("t2_beats", beats, N);
      chk("t2_data", dat_err + se_err + rd_bad, 0);
      last_ch = ec;
    end
    chk("t2_gap_ok", min_gap >= 3, 1);

    push(0, N);
    bus.ch_end = 2'b01;
    ec = rr(2'b01);
    watch(ec, 1'b1, 3000, 0);
    bus.ch_end = 2'b00;
    bus.snk_ready = 1'b1;
    chk("t3_beats", beats, N);
    chk("t3_data", dat_err, 0);
    chk("t3_sop_eop", se_err, 0);
    chk("t3_rd_when_busy", rd_bad, 0);
    last_ch = ec;

    push(0, N);
    bus.ch_end = 2'b01;
    ec = rr(2'b01);
    watch(ec, 1'b0, 3000, 500);
    Reset = 1'b1;
    bus.ch_end = 2'b00;
    @(negedge Clk);
    chk("t4_valid", bus.snk_valid, 0);
    chk("t4_sop_eop", {bus.snk_sop, bus.snk_eop}, 0);
    chk("t4_rdreq", bus.ch_rdreq, 0);
    chk("t4_rearm", bus.ch_rearm, 0);
    chk("t4_busy_done", {bus.busy, bus.frame_done}, 0);
    chk("t4_real", bus.snk_real, 0);
    chk("t4_frame_ch", bus.frame_ch, 0);
    Reset = 1'b0;
    last_ch = 1;
    last_eop = -1;
    do_flush();
    push(0, N);
    push(1, N);
    bus.ch_end = 2'b11;
    ec = rr(2'b11);
    watch(ec, 1'b0, 3000, 0);
    bus.ch_end = 2'b00;
    chk("t4_new_ch", bus.frame_ch, 0);
    chk("t4_new_beats", beats, N);
    chk("t4_new_data", dat_err + se_err, 0);
    do_flush();

    do_reset();
    push(0, 300);
    bus.ch_end = 2'b01;
    ec = rr(2'b01);
`ifdef FFT_SCHED_UNDERRUN_PAD_EN
    watch(ec, 1'b0, 3000, 0);
    bus.ch_end = 2'b00;
    chk("t5_beats", beats, N);
    chk("t5_pad_data", dat_err, 0);
    chk("t5_sop_eop", se_err, 0);
    chk("t5_done", done_cnt, 1);
    repeat (5) @(negedge Clk);
    chk("t5_underrun", bus.underrun, 1);
    do_reset();
    chk("t5_underrun_clr", bus.underrun, 0);
`else
    watch(ec, 1'b0, 400, 0);
    chk("t5_beats", beats, 300);
    chk("t5_data", dat_err, 0);
    chk("t5_done", done_cnt, 0);
    chk("t5_busy", bus.busy, 1);
    chk("t5_underrun", bus.underrun, 0);
    bus.ch_end = 2'b00;
    do_reset();
    chk("t5_busy_rst", bus.busy, 0);
`endif
    do_flush();

    push(1, 16);
    bus.ch_en = 2'b01;
    bus.ch_end = 2'b10;
    bad6 = 0;
    repeat (20) begin
      @(negedge Clk);
      if (bus.ch_rdreq != 2'b00 || bus.busy) bad6++;
    end
    chk("t6_idle_cycles", bad6, 0);
    chk("t6_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
